// File: rtl/afifo_pkg.sv
// ==[ afifo_pkg ]== Shared async-FIFO constants and Gray/binary helpers  (rev 1.0)
`default_nettype none
package afifo_pkg;
  localparam int AFIFO_PTRWIDTH = 4;
  localparam int AFIFO_DWIDTH   = 8;
  localparam int AFIFO_MAXW     = 32;

  // Helpers work on a wide zero-extended word; callers cast back to their width.
  function automatic logic [AFIFO_MAXW-1:0] bin2gray(input logic [AFIFO_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AFIFO_MAXW-1:0] gray2bin(input logic [AFIFO_MAXW-1:0] g);
    logic [AFIFO_MAXW-1:0] b;
    b[AFIFO_MAXW-1] = g[AFIFO_MAXW-1];
    for (int i = AFIFO_MAXW-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
endpackage
`default_nettype wire

// File: rtl/rptr_empty_fwft_if.sv
// ==[ rptr_empty_fwft_if ]== Read-side FIFO bus: pointers, buffer port, FWFT handshake  (rev 1.0)
`default_nettype none
interface rptr_empty_fwft_if
  import afifo_pkg::*;
#(
  parameter int PTRWIDTH = AFIFO_PTRWIDTH,
  parameter int DWIDTH   = AFIFO_DWIDTH
) ();
  logic [PTRWIDTH-1:0] rq2wptr;
  logic [DWIDTH-1:0]   rdata_mem;
  logic                dout_ready;
  logic [PTRWIDTH-1:0] rptr;
  logic [PTRWIDTH-2:0] raddr;
  logic                rempty;
  logic [DWIDTH-1:0]   dout;
  logic                dout_valid;
  logic [PTRWIDTH-1:0] rcount;

  modport master (
    input  rq2wptr, rdata_mem, dout_ready,
    output rptr, raddr, rempty, dout, dout_valid, rcount
  );

  modport slave (
    output rq2wptr, rdata_mem, dout_ready,
    input  rptr, raddr, rempty, dout, dout_valid, rcount
  );
endinterface
`default_nettype wire

// File: rtl/fwft_outreg.sv
// ==[ fwft_outreg ]== Registered head-word stage: load on strobe, drain on transfer  (rev 1.0)
`default_nettype none
module fwft_outreg
  import afifo_pkg::*;
#(
  parameter int DWIDTH = AFIFO_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              ready,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_valid
);
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    if (load) begin
      dout_d  = din;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
endmodule
`default_nettype wire

// File: rtl/rptr_empty_fwft.sv
// ==[ rptr_empty_fwft ]== Async-FIFO read pointer, empty flag and FWFT output stage  (rev 1.0)
`default_nettype none
module rptr_empty_fwft
  import afifo_pkg::*;
#(
  parameter int PTRWIDTH = AFIFO_PTRWIDTH,
  parameter int DWIDTH   = AFIFO_DWIDTH
) (
  input  logic                 rclk,
  input  logic                 rreset,
  rptr_empty_fwft_if.master    bus
);
  logic [PTRWIDTH-1:0] rbin_q, rbin_d;
  logic [PTRWIDTH-1:0] rptr_q, rptr_d;
  logic                rempty_q, rempty_d;
  logic [PTRWIDTH-1:0] rcount_q, rcount_d;
  logic [PTRWIDTH-1:0] rgnext;
  logic [PTRWIDTH-1:0] wbin_sync;
  logic                rinc;
  logic                dout_valid;

  // Pop is gated by the registered empty flag, so the read side never passes rq2wptr.
  assign rinc      = ~rempty_q & (~dout_valid | bus.dout_ready);
  assign rbin_d    = rbin_q + {{(PTRWIDTH-1){1'b0}}, rinc};
  assign rgnext    = PTRWIDTH'(bin2gray(AFIFO_MAXW'(rbin_d)));
  assign wbin_sync = PTRWIDTH'(gray2bin(AFIFO_MAXW'(bus.rq2wptr)));

  always_comb begin
    rptr_d   = rgnext;
    rempty_d = (rgnext == bus.rq2wptr);
    rcount_d = wbin_sync - rbin_d;
  end

  always_ff @(posedge rclk) begin
    if (rreset) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rcount_q <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rcount_q <= rcount_d;
    end
  end

  fwft_outreg #(.DWIDTH(DWIDTH)) u_outreg (
    .clk        (rclk),
    .rst        (rreset),
    .load       (rinc),
    .ready      (bus.dout_ready),
    .din        (bus.rdata_mem),
    .dout       (bus.dout),
    .dout_valid (dout_valid)
  );

  assign bus.dout_valid = dout_valid;
  assign bus.rptr       = rptr_q;
  assign bus.raddr      = rbin_q[PTRWIDTH-2:0];
  assign bus.rempty     = rempty_q;
  assign bus.rcount     = rcount_q;
endmodule
`default_nettype wire
